multicycle_control_fsm: RTL and testbench

//  Multicycle control unit: Moore FSM sequencing fetch, decode, execute, memory and writeback.

---
 rtl/multicycle_control_fsm.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Moore control unit for a multicycle MIPS-like datapath: fetch/decode/execute/memory/writeback
// sequencing with programmable memory wait states. State register updates on the falling edge.
//
// state      | meaning
// RESET      | held in reset, all controls idle
// FETCH      | read instruction at PC, PC <= PC + 4
// FWAIT      | memory wait after instruction fetch
// IRWR       | load instruction register
// DECODE     | register read, branch target precompute, opcode dispatch
// MEM_ADDR   | base + sign-ext offset (also ADDI sum)
// ADDI_WB    | write ALUOut to rt
// MEM_READ   | issue data read, load MDR
// MRWAIT     | memory wait after data read
// MEM_WB     | write MDR to rt
// MEM_WRITE  | single-cycle data write
// R_EXEC     | ALU op from funct field
// R_WB       | write ALUOut to rd
// BRANCH     | compare A,B; PC <= target if zero
// JUMP       | PC <= jump target
// EXCEPTION  | PC <= exception vector, flag pulse
module multicycle_control_fsm #(
    parameter int MEM_WAIT = 1,
    parameter int OPCODE_W = 6,
    parameter int ULAOP_W  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] OPcode,
    output logic [1:0]          SrcPC,
    output logic                ULASrcA,
    output logic [1:0]          ULASrcB,
    output logic                EscReg,
    output logic                RegDst,
    output logic                IREsc,
    output logic                Mem2Reg,
    output logic                WriteMem,
    output logic                StoreMem,
    output logic [ULAOP_W-1:0]  ULAOp,
    output logic                IorD,
    output logic                PCWri,
    output logic                PCWriCond,
    output logic                Excecao,
    output logic [4:0]          stateout
);

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_FWAIT     = 5'd2,
        S_IRWR      = 5'd3,
        S_DECODE    = 5'd4,
        S_MEM_ADDR  = 5'd5,
        S_ADDI_WB   = 5'd6,
        S_MEM_READ  = 5'd7,
        S_MRWAIT    = 5'd8,
        S_MEM_WB    = 5'd9,
        S_MEM_WRITE = 5'd10,
        S_R_EXEC    = 5'd11,
        S_R_WB      = 5'd12,
        S_BRANCH    = 5'd13,
        S_JUMP      = 5'd14,
        S_EXCEPTION = 5'd15
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);

    localparam logic [ULAOP_W-1:0] ALU_ADD   = ULAOP_W'(3'b001);
    localparam logic [ULAOP_W-1:0] ALU_SUB   = ULAOP_W'(3'b010);
    localparam logic [ULAOP_W-1:0] ALU_FUNCT = ULAOP_W'(3'b111);

    localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;

    // Counter reloads only on entry to a wait state so the dwell is exactly MEM_WAIT cycles.
    always_ff @(negedge clock) begin
        if (!reset) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next == S_FWAIT || w_next == S_MRWAIT) && (w_next != r_state))
                r_cnt <= WAIT_LOAD;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:     w_next = S_FETCH;
            S_FETCH:     w_next = HAS_WAIT ? S_FWAIT : S_IRWR;
            S_FWAIT:     w_next = (r_cnt == 4'd0) ? S_IRWR : S_FWAIT;
            S_IRWR:      w_next = S_DECODE;
            S_DECODE: begin
                case (OPcode)
                    OP_R:                   w_next = S_R_EXEC;
                    OP_ADDI, OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:                 w_next = S_BRANCH;
                    OP_J:                   w_next = S_JUMP;
                    default:                w_next = S_EXCEPTION;
                endcase
            end
            S_MEM_ADDR: begin
                case (OPcode)
                    OP_ADDI: w_next = S_ADDI_WB;
                    OP_LW:   w_next = S_MEM_READ;
                    OP_SW:   w_next = S_MEM_WRITE;
                    default: w_next = S_EXCEPTION;
                endcase
            end
            S_MEM_READ:  w_next = HAS_WAIT ? S_MRWAIT : S_MEM_WB;
            S_MRWAIT:    w_next = (r_cnt == 4'd0) ? S_MEM_WB : S_MRWAIT;
            S_ADDI_WB, S_MEM_WB, S_MEM_WRITE, S_R_WB,
            S_BRANCH, S_JUMP, S_EXCEPTION:
                         w_next = S_FETCH;
            S_R_EXEC:    w_next = S_R_WB;
            default:     w_next = S_RESET;
        endcase
    end

    always_comb begin
        SrcPC     = 2'b00;
        ULASrcA   = 1'b0;
        ULASrcB   = 2'b00;
        EscReg    = 1'b0;
        RegDst    = 1'b0;
        IREsc     = 1'b0;
        Mem2Reg   = 1'b0;
        WriteMem  = 1'b0;
        StoreMem  = 1'b0;
        ULAOp     = ALU_ADD;
        IorD      = 1'b0;
        PCWri     = 1'b0;
        PCWriCond = 1'b0;
        Excecao   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ULASrcB = 2'b01;
                PCWri   = 1'b1;
            end
            S_IRWR:      IREsc = 1'b1;
            S_DECODE:    ULASrcB = 2'b11;
            S_MEM_ADDR: begin
                ULASrcA = 1'b1;
                ULASrcB = 2'b10;
            end
            S_ADDI_WB:   EscReg = 1'b1;
            S_MEM_READ: begin
                IorD     = 1'b1;
                StoreMem = 1'b1;
            end
            S_MEM_WB: begin
                EscReg  = 1'b1;
                Mem2Reg = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                WriteMem = 1'b1;
            end
            S_R_EXEC: begin
                ULASrcA = 1'b1;
                ULAOp   = ALU_FUNCT;
            end
            S_R_WB: begin
                EscReg = 1'b1;
                RegDst = 1'b1;
            end
            S_BRANCH: begin
                ULASrcA   = 1'b1;
                ULAOp     = ALU_SUB;
                SrcPC     = 2'b01;
                PCWriCond = 1'b1;
            end
            S_JUMP: begin
                SrcPC = 2'b10;
                PCWri = 1'b1;
            end
            S_EXCEPTION: begin
                SrcPC   = 2'b11;
                PCWri   = 1'b1;
                Excecao = 1'b1;
            end
            default: ;
        endcase
    end

    assign stateout = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: three instances (MEM_WAIT 0/1/3) checked cycle by cycle
// against per-instruction expected control-word sequences built from the instruction rules.
module tb_multicycle_control_fsm;

    localparam int WV [3] = '{0, 1, 3};

    logic       clock;
    logic       reset;
    logic [5:0] opc  [3];
    logic [1:0] w_src [3];
    logic       w_asa [3];
    logic [1:0] w_asb [3];
    logic       w_esc [3];
    logic       w_rdst [3];
    logic       w_ire [3];
    logic       w_m2r [3];
    logic       w_wm [3];
    logic       w_sm [3];
    logic [2:0] w_uop [3];
    logic       w_iord [3];
    logic       w_pcw [3];
    logic       w_pcwc [3];
    logic       w_exc [3];
    logic [4:0] w_st [3];

    int n_total = 0;
    int n_bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control_fsm #(.MEM_WAIT(WV[g]), .OPCODE_W(6), .ULAOP_W(3)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .OPcode   (opc[g]),
            .SrcPC    (w_src[g]),
            .ULASrcA  (w_asa[g]),
            .ULASrcB  (w_asb[g]),
            .EscReg   (w_esc[g]),
            .RegDst   (w_rdst[g]),
            .IREsc    (w_ire[g]),
            .Mem2Reg  (w_m2r[g]),
            .WriteMem (w_wm[g]),
            .StoreMem (w_sm[g]),
            .ULAOp    (w_uop[g]),
            .IorD     (w_iord[g]),
            .PCWri    (w_pcw[g]),
            .PCWriCond(w_pcwc[g]),
            .Excecao  (w_exc[g]),
            .stateout (w_st[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Control word: {SrcPC, ULASrcA, ULASrcB, EscReg, RegDst, IREsc, Mem2Reg, WriteMem, StoreMem, ULAOp, IorD, PCWri, PCWriCond, Excecao}
    function automatic logic [17:0] mk(input logic [1:0] srcpc, input logic a, input logic [1:0] b,
                                       input logic esc, input logic rdst, input logic ire, input logic m2r,
                                       input logic wm, input logic sm, input logic [2:0] op,
                                       input logic iord, input logic pcw, input logic pcwc, input logic exc);
        return {srcpc, a, b, esc, rdst, ire, m2r, wm, sm, op, iord, pcw, pcwc, exc};
    endfunction

    localparam logic [17:0] V_IDLE   = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_FETCH  = mk(2'b00, 0, 2'b01, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 0);
    localparam logic [17:0] V_IRWR   = mk(2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_DECODE = mk(2'b00, 0, 2'b11, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_MADDR  = mk(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_ADDIWB = mk(2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_MREAD  = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b001, 1, 0, 0, 0);
    localparam logic [17:0] V_MWB    = mk(2'b00, 0, 2'b00, 1, 0, 0, 1, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_MWRITE = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'b001, 1, 0, 0, 0);
    localparam logic [17:0] V_REXEC  = mk(2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
    localparam logic [17:0] V_RWB    = mk(2'b00, 0, 2'b00, 1, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    localparam logic [17:0] V_BRANCH = mk(2'b01, 1, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 1, 0);
    localparam logic [17:0] V_JUMP   = mk(2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 0);
    localparam logic [17:0] V_EXC    = mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1);

    function automatic logic [17:0] obs(input int k);
        return {w_src[k], w_asa[k], w_asb[k], w_esc[k], w_rdst[k], w_ire[k], w_m2r[k],
                w_wm[k], w_sm[k], w_uop[k], w_iord[k], w_pcw[k], w_pcwc[k], w_exc[k]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Runs one instruction on instance k, starting just before the posedge that shows FETCH.
    task automatic run_one(input int k, input logic [5:0] op);
        logic [17:0] q[$];
        logic [17:0] o;
        int w;
        w = WV[k];
        opc[k] = op;
        q.push_back(V_FETCH);
        repeat (w) q.push_back(V_IDLE);
        q.push_back(V_IRWR);
        q.push_back(V_DECODE);
        case (op)
            6'h00: begin q.push_back(V_REXEC); q.push_back(V_RWB); end
            6'h08: begin q.push_back(V_MADDR); q.push_back(V_ADDIWB); end
            6'h23: begin
                q.push_back(V_MADDR);
                q.push_back(V_MREAD);
                repeat (w) q.push_back(V_IDLE);
                q.push_back(V_MWB);
            end
            6'h2B: begin q.push_back(V_MADDR); q.push_back(V_MWRITE); end
            6'h04: q.push_back(V_BRANCH);
            6'h02: q.push_back(V_JUMP);
            default: q.push_back(V_EXC);
        endcase
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clock);
            o = obs(k);
            chk($sformatf("w%0d op%02h cyc%0d", w, op, i), 32'(o), 32'(q[i]));
            chk($sformatf("w%0d wm_esc_excl", w), 32'(o[8] & o[12]), 32'd0);
            chk($sformatf("w%0d pcw_pcwc_excl", w), 32'(o[2] & o[1]), 32'd0);
        end
    endtask

    task automatic run_prog(input int k);
        logic [5:0] fixed_ops [7];
        logic [5:0] op;
        int r;
        fixed_ops = '{6'h00, 6'h23, 6'h2B, 6'h3F, 6'h08, 6'h04, 6'h02};
        for (int i = 0; i < 7; i++) run_one(k, fixed_ops[i]);
        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 7));
            op = (r < 7) ? fixed_ops[r] : 6'($urandom);
            run_one(k, op);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 3; k++) opc[k] = 6'h00;
        @(negedge clock);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            for (int k = 0; k < 3; k++)
                chk($sformatf("reset_hold k%0d c%0d", k, c), 32'(obs(k)), 32'(V_IDLE));
        end
        reset = 1'b1;
        fork
            run_prog(0);
            run_prog(1);
            run_prog(2);
        join

        // Reset while instance 0 is mid-store.
        reset = 1'b0;
        @(posedge clock);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_async_pt k%0d", k), 32'(obs(k)), 32'(V_IDLE));
        reset = 1'b1;
        for (int k = 0; k < 3; k++) opc[k] = 6'h2B;
        begin
            logic [17:0] sw_seq [5];
            sw_seq = '{V_FETCH, V_IRWR, V_DECODE, V_MADDR, V_MWRITE};
            for (int i = 0; i < 5; i++) begin
                @(posedge clock);
                chk($sformatf("sw_pre_reset cyc%0d", i), 32'(obs(0)), 32'(sw_seq[i]));
            end
        end
        reset = 1'b0;
        @(posedge clock);
        chk("sw_reset_wm", 32'(w_wm[0]), 32'd0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("sw_reset_state k%0d", k), 32'(obs(k)), 32'(V_IDLE));
        reset = 1'b1;
        fork
            begin run_one(0, 6'h04); run_one(0, 6'h02); end
            begin run_one(1, 6'h04); run_one(1, 6'h02); end
            begin run_one(2, 6'h04); run_one(2, 6'h02); end
        join

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
